// File: rtl/alu_seq_unit_if.sv
// rtl/alu_seq_unit_if.sv - request/result bundle between the register file side and alu_seq_unit
//   A, B      : operands (register-file OutA / OutB)
//   FunSel    : operation select
//   Start, WF : operation request and flag-write enable, sampled together
//   ALUOut    : registered result
//   FlagsOut  : registered {Z,C,N,O}
//   Busy      : multiply in progress
//   Done      : one-cycle result-valid pulse
interface alu_seq_unit_if #(
    parameter int DW = 32
);
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [3:0]    FunSel;
    logic          Start;
    logic          WF;
    logic [DW-1:0] ALUOut;
    logic [3:0]    FlagsOut;
    logic          Busy;
    logic          Done;

    modport master (
        output A, B, FunSel, Start, WF,
        input  ALUOut, FlagsOut, Busy, Done
    );

    modport slave (
        input  A, B, FunSel, Start, WF,
        output ALUOut, FlagsOut, Busy, Done
    );
endinterface

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - single-cycle ALU with a 32-iteration shift-add multiplier and registered flags
//   Clock  : rising-edge clock
//   ResetN : asynchronous active-low reset
//   bus    : alu_seq_unit_if.slave (A, B, FunSel, Start, WF in; ALUOut, FlagsOut, Busy, Done out)
module alu_seq_unit #(
    parameter int DW = 32
) (
    input  logic          Clock,
    input  logic          ResetN,
    alu_seq_unit_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam logic [3:0] FS_ADD  = 4'b0100;
    localparam logic [3:0] FS_ADC  = 4'b0101;
    localparam logic [3:0] FS_SUB  = 4'b0110;
    localparam logic [3:0] FS_MUL  = 4'b1110;

    // Flag bit positions in {Z,C,N,O}
    localparam int FZ = 3;
    localparam int FC = 2;
    localparam int FN = 1;
    localparam int FO = 0;

    logic [0:0]    r_state;
    logic [DW-1:0] r_out;
    logic [3:0]    r_flags;
    logic          r_done;
    logic          r_wf;
    logic [5:0]    r_cnt;
    logic [DW-1:0] r_mcand;
    logic [DW-1:0] r_mplier;
    logic [DW-1:0] r_acc;

    logic [DW-1:0] w_res;
    logic          w_c;
    logic          w_o;
    logic [DW-1:0] w_bx;
    logic          w_cin;
    logic [DW:0]   w_sum;
    logic [3:0]    w_flags_new;
    logic [DW-1:0] w_mul_acc;
    logic [3:0]    w_mul_flags;
    logic          w_accept;

    assign w_accept = bus.Start && (r_state == IDLE);

    // Add, add-with-carry and subtract share one adder; subtract is A + ~B + 1,
    // so its carry-out is the inverted borrow.
    always_comb begin
        w_bx  = (bus.FunSel == FS_SUB) ? ~bus.B : bus.B;
        w_cin = (bus.FunSel == FS_SUB) ? 1'b1 :
                (bus.FunSel == FS_ADC) ? r_flags[FC] : 1'b0;
        w_sum = {1'b0, bus.A} + {1'b0, w_bx} + {{DW{1'b0}}, w_cin};
    end

    always_comb begin
        w_res = '0;
        w_c   = r_flags[FC];
        w_o   = r_flags[FO];
        case (bus.FunSel)
            4'b0000: w_res = bus.A;
            4'b0001: w_res = bus.B;
            4'b0010: w_res = ~bus.A;
            4'b0011: w_res = ~bus.B;
            FS_ADD, FS_ADC, FS_SUB: begin
                w_res = w_sum[DW-1:0];
                w_c   = w_sum[DW];
                w_o   = (bus.A[DW-1] == w_bx[DW-1]) && (w_res[DW-1] != bus.A[DW-1]);
            end
            4'b0111: w_res = bus.A & bus.B;
            4'b1000: w_res = bus.A | bus.B;
            4'b1001: w_res = bus.A ^ bus.B;
            4'b1010: begin
                w_res = {bus.A[DW-2:0], 1'b0};
                w_c   = bus.A[DW-1];
            end
            4'b1011: begin
                w_res = {1'b0, bus.A[DW-1:1]};
                w_c   = bus.A[0];
            end
            4'b1100: begin
                w_res = {bus.A[DW-1], bus.A[DW-1:1]};
                w_c   = bus.A[0];
            end
            4'b1101: begin
                w_res = {bus.A[DW-2:0], r_flags[FC]};
                w_c   = bus.A[DW-1];
            end
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_flags_new     = 4'b0000;
        w_flags_new[FZ] = (w_res == '0);
        w_flags_new[FC] = w_c;
        w_flags_new[FN] = w_res[DW-1];
        w_flags_new[FO] = w_o;
    end

    // One shift-add step: multiplicand walks left, multiplier walks right.
    assign w_mul_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Multiply only touches Z and N; C and O carry through.
    always_comb begin
        w_mul_flags     = r_flags;
        w_mul_flags[FZ] = (w_mul_acc == '0);
        w_mul_flags[FN] = w_mul_acc[DW-1];
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state  <= IDLE;
            r_out    <= '0;
            r_flags  <= 4'b0000;
            r_done   <= 1'b0;
            r_wf     <= 1'b0;
            r_cnt    <= 6'd0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (bus.FunSel == FS_MUL) begin
                            r_state  <= MUL;
                            r_wf     <= bus.WF;
                            r_mcand  <= bus.A;
                            r_mplier <= bus.B;
                            r_acc    <= '0;
                            r_cnt    <= 6'd0;
                        end else begin
                            r_out  <= w_res;
                            r_done <= 1'b1;
                            if (bus.WF) begin
                                r_flags <= w_flags_new;
                            end
                        end
                    end
                end
                MUL: begin
                    r_acc    <= w_mul_acc;
                    r_mcand  <= {r_mcand[DW-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[DW-1:1]};
                    r_cnt    <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= IDLE;
                        r_cnt   <= 6'd0;
                        r_out   <= w_mul_acc;
                        r_done  <= 1'b1;
                        if (r_wf) begin
                            r_flags <= w_mul_flags;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ALUOut   = r_out;
    assign bus.FlagsOut = r_flags;
    assign bus.Busy     = (r_state == MUL);
    assign bus.Done     = r_done;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard testbench for alu_seq_unit
module tb_alu_seq_unit;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   mul_lo   = -1;
    int   mul_hi   = -2;
    logic [3:0] m_flags = 4'b0000;

    typedef struct {
        logic [31:0] out;
        logic [3:0]  fl;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    alu_seq_unit_if bus_if ();

    alu_seq_unit dut (
        .Clock  (clk),
        .ResetN (rst_n),
        .bus    (bus_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s act=%h exp=%h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] fl, output logic [31:0] r, output logic [3:0] nf);
        logic        c;
        logic        o;
        logic [32:0] w;
        longint      sa;
        longint      sb;
        longint      sr;
        c  = fl[2];
        o  = fl[0];
        r  = 32'h0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (fs)
            4'h0: r = a;
            4'h1: r = b;
            4'h2: r = ~a;
            4'h3: r = ~b;
            4'h4, 4'h5: begin
                w  = {1'b0, a} + {1'b0, b} + ((fs == 4'h5) ? {32'h0, fl[2]} : 33'h0);
                r  = w[31:0];
                c  = w[32];
                sr = sa + sb + ((fs == 4'h5) ? longint'(fl[2]) : 64'sd0);
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h6: begin
                r  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h7: r = a & b;
            4'h8: r = a | b;
            4'h9: r = a ^ b;
            4'hA: begin r = a << 1; c = a[31]; end
            4'hB: begin r = a >> 1; c = a[0]; end
            4'hC: begin r = $unsigned($signed(a) >>> 1); c = a[0]; end
            4'hD: begin r = {a[30:0], fl[2]}; c = a[31]; end
            4'hE: r = a * b;
            default: r = 32'h0;
        endcase
        nf = {(r == 32'h0), c, r[31], o};
    endfunction

    // Drive a request in the current cycle; it is accepted at the next rising edge.
    task automatic drive(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b, input logic wf);
        exp_t        e;
        logic [31:0] r;
        logic [3:0]  nf;
        bus_if.Start  = 1'b1;
        bus_if.FunSel = fs;
        bus_if.A      = a;
        bus_if.B      = b;
        bus_if.WF     = wf;
        model(fs, a, b, m_flags, r, nf);
        if (wf) m_flags = nf;
        e.out = r;
        e.fl  = m_flags;
        if (fs == 4'hE) begin
            e.cyc  = cyc + 33;
            mul_lo = cyc + 1;
            mul_hi = cyc + 32;
        end else begin
            e.cyc = cyc + 1;
        end
        q.push_back(e);
    endtask

    task automatic op(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b, input logic wf);
        @(negedge clk);
        drive(fs, a, b, wf);
    endtask

    // Inputs wander after the accepting edge; results must not follow them.
    task automatic idle();
        @(negedge clk);
        bus_if.Start  = 1'b0;
        bus_if.FunSel = 4'($urandom_range(0, 15));
        bus_if.A      = $urandom;
        bus_if.B      = $urandom;
        bus_if.WF     = 1'($urandom_range(0, 1));
    endtask

    task automatic poke();
        @(negedge clk);
        bus_if.Start  = 1'b1;
        bus_if.FunSel = 4'($urandom_range(0, 15));
        bus_if.A      = $urandom;
        bus_if.B      = $urandom;
        bus_if.WF     = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check_eq("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("busy", bus_if.Busy, (cyc >= mul_lo && cyc <= mul_hi));
            if (bus_if.Done) begin
                if (q.size() == 0) begin
                    check_eq("spurious_done", bus_if.Done, 0);
                end else begin
                    mon_e = q.pop_front();
                    check_eq("done_cyc", cyc, mon_e.cyc);
                    check_eq("aluout", bus_if.ALUOut, mon_e.out);
                    check_eq("flags", bus_if.FlagsOut, mon_e.fl);
                end
            end else if (q.size() != 0 && q[0].cyc < cyc) begin
                check_eq("done_missing", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  fs;
        logic [31:0] a;
        logic [31:0] b;
        bus_if.Start  = 1'b0;
        bus_if.FunSel = 4'h0;
        bus_if.A      = 32'h0;
        bus_if.B      = 32'h0;
        bus_if.WF     = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_out", bus_if.ALUOut, 32'h0);
        check_eq("rst_flags", bus_if.FlagsOut, 4'h0);
        check_eq("rst_busy", bus_if.Busy, 0);
        check_eq("rst_done", bus_if.Done, 0);
        rst_n = 1'b1;

        op(4'h4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        idle();
        check_eq("add_wrap_out", bus_if.ALUOut, 32'h0);
        check_eq("add_wrap_flags", bus_if.FlagsOut, 4'hC);
        check_eq("add_wrap_done", bus_if.Done, 1);
        idle();
        check_eq("done_one_cycle", bus_if.Done, 0);

        op(4'h6, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        idle();
        check_eq("sub_ovf_out", bus_if.ALUOut, 32'h8000_0000);
        check_eq("sub_ovf_flags", bus_if.FlagsOut, 4'h3);

        // Set C, rotate through it, then an AND with WF=0 must leave flags alone.
        op(4'h6, 32'h5, 32'h3, 1'b1);
        op(4'hD, 32'h8000_0000, 32'h0, 1'b1);
        op(4'h7, 32'h0000_FFFF, 32'h0000_0F0F, 1'b0);
        check_eq("rol_out", bus_if.ALUOut, 32'h1);
        check_eq("rol_flags", bus_if.FlagsOut, 4'h4);
        idle();
        check_eq("and_out", bus_if.ALUOut, 32'h0F0F);
        check_eq("and_flags_kept", bus_if.FlagsOut, 4'h4);

        for (int i = 0; i < 40; i++) begin
            fs = 4'(i % 16);
            if (fs == 4'hE) fs = 4'h5;
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            op(fs, a, b, 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        wait_idle();

        op(4'hE, 32'h0001_0003, 32'h0000_0005, 1'b1);
        idle();
        repeat (12) begin
            poke();
            idle();
        end
        wait_idle();
        check_eq("mul_out", bus_if.ALUOut, 32'h0005_000F);

        repeat (3) begin
            op(4'hE, $urandom, $urandom, 1'($urandom_range(0, 1)));
            idle();
            wait_idle();
            op(4'($urandom_range(0, 13)), $urandom, $urandom, 1'b1);
            idle();
        end
        wait_idle();

        op(4'h0, 32'hDEAD_BEEF, 32'h0, 1'b1);
        op(4'hE, 32'hFFFF_1234, 32'h0000_ABCD, 1'b1);
        idle();
        repeat (10) @(posedge clk);
        #3;
        rst_n   = 1'b0;
        q.delete();
        mul_lo  = -1;
        mul_hi  = -2;
        m_flags = 4'h0;
        #1;
        check_eq("abort_out", bus_if.ALUOut, 32'h0);
        check_eq("abort_flags", bus_if.FlagsOut, 4'h0);
        check_eq("abort_busy", bus_if.Busy, 0);
        check_eq("abort_done", bus_if.Done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(4'h4, 32'h2, 32'h3, 1'b1);
        idle();
        check_eq("first_accept_out", bus_if.ALUOut, 32'h5);
        repeat (40) idle();
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
